byte_packer: RTL
================

Name: byte_packer

Overview:
- Byte-stream front end for the sponge datapath.
- Packs an 8-bit message stream into 64-bit words and drives the word-input side of `padder`: `in`, `in_ready`, `is_last`, `byte_num`, and the returned `ack`.
- Acts as the transmitter for the padder's input handshake.
- Marks the final partial word with its valid-byte count so that `padder` can append the Keccak padding.

Parameters:
- LEN_W, 32, width of the optional message-length counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset (asserted at 0)
- byte_in  in  8  message byte
- byte_valid  in  1  byte_in carries a valid byte this cycle
- byte_last  in  1  end of message; may be asserted with byte_valid=0 to end a message without a byte (empty message, or length that is a multiple of 8)
- byte_ready  out  1  packer accepts byte_in/byte_last this cycle
- out  out  64  packed word; connects to padder `in`
- out_ready  out  1  word valid; connects to padder `in_ready`
- is_last  out  1  final word of the message
- byte_num  out  3  valid bytes in the final word (0..7); meaningful only when is_last=1
- ack  in  1  padder consumed the word this cycle
- msg_len  out  LEN_W  byte count of the current message (only when the optional feature is compiled in)

Behaviour:
- Reset (reset=0, async), all outputs cleared:
  - byte_ready=0 until reset deasserts, then 1 on the first rising edge
  - out=0, out_ready=0, is_last=0, byte_num=0, internal count=0, state FILL
- Byte lane order: byte k of a word (k=0..7, in arrival order) occupies out[8k+7:8k]. Unused lanes of a final word are 0.
- Input transfer: occurs on a rising edge with byte_ready=1 and (byte_valid=1 or byte_last=1).
- State FILL (byte_ready=1, out_ready=0):
  - valid byte, byte_last=0: store the byte in lane cnt; cnt++.
  - If this was the 8th byte (cnt 7->0): load the word, is_last=0, go to SEND. out_ready rises the next cycle.
  - byte_last=1 with byte_valid=1: store the byte, n=cnt+1.
    - n=8: send a full word with is_last=0, then go to SEND_EMPTY.
    - n<8: send a word with is_last=1, byte_num=n, go to SEND.
  - byte_last=1 with byte_valid=0: send the word with is_last=1, byte_num=cnt (may be 0, giving an all-zero word), go to SEND.
- State SEND (out_ready=1, byte_ready=0):
  - out, is_last and byte_num are held stable until ack=1.
  - On ack: out_ready=0, is_last=0, cnt=0, go to FILL.
- State SEND_EMPTY:
  - After ack of the full word, present out=0, is_last=1, byte_num=0, then go to SEND.
  - byte_ready stays 0 throughout.
- ack while out_ready=0 is ignored.
- Latency: the word appears 1 cycle after the completing input transfer. Accepting further bytes resumes 1 cycle after ack.
- Throughput: at most one word per 9 cycles. This is acceptable because padder throughput is bounded by the permutation.
- Reset mid-SEND: the word is dropped and out_ready falls immediately (asynchronous).
- byte_valid=0 and byte_last=0: no state change.

Optional Feature:
- Macro BYTE_PACKER_LEN_COUNT_EN.
- Defined:
  - msg_len counts the bytes accepted for the current message; it saturates at all-ones.
  - It is frozen after the byte_last transfer and stays visible until the first transfer of the next message, which loads 1 (or 0 for a bare byte_last).
- Undefined: the msg_len port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package sha3_pkg holds:
  - the state encoding (FILL, SEND, SEND_EMPTY)
  - constants WORD_BYTES=8 and BYTE_W=8, also used by padder
- One sub-module, byte_lane_reg: 8x8 lane register with per-lane write enable and clear. The FSM stays in byte_packer.

Test Plan:
- Reset, then byte_last=1 with byte_valid=0 -> one word: out=0, is_last=1, byte_num=0. It is held across 5 cycles with ack=0 and drops the cycle after ack.
- Bytes 0xEF,0xCD,0xAB,0x90,0x78,0x56,0x34,0x12 with no last -> out=64'h1234567890ABCDEF, is_last=0, and byte_ready=0 until ack.
- Six bytes 0xEF,0xCD,0xAB,0x90,0x78,0x56, byte_last on the 6th -> out=64'h0000567890ABCDEF, is_last=1, byte_num=6.
- Eight bytes with byte_last on the 8th -> full word with is_last=0 after ack, then a zero word with is_last=1, byte_num=0, with no bytes accepted in between.
- ack held at 0 for 20 cycles while bytes keep arriving -> out is stable, byte_ready=0, no byte lost; the next word is correct after ack.
- With BYTE_PACKER_LEN_COUNT_EN, a 13-byte message -> msg_len=13 after the last transfer; the next message's first byte -> msg_len=1.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared definitions for the sponge front end: packer state encoding and
// the byte/word geometry that the packer and the padder agree on.
package sha3_pkg;

    localparam int WORD_BYTES = 8;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int CNT_W      = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        SEND       = 2'd1,
        SEND_EMPTY = 2'd2
    } pack_state_e;

    // Byte placed in its lane of an otherwise zero word.
    function automatic logic [WORD_W-1:0] place_byte(input logic [BYTE_W-1:0] b,
                                                     input logic [CNT_W-1:0]  lane);
        return {{(WORD_W-BYTE_W){1'b0}}, b} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// Eight byte lanes assembling one packed word; per-lane write enable,
// synchronous clear with priority over writes.
module byte_lane_reg
    import sha3_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [WORD_BYTES-1:0] wr_en,
    input  logic [BYTE_W-1:0]     wr_data,
    output logic [WORD_W-1:0]     lanes
);

    logic [WORD_W-1:0] lanes_q, lanes_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        lanes_d = lanes_q;
        if (clr) begin
            lanes_d = '0;
        end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (wr_en[k]) lanes_d[k*BYTE_W +: BYTE_W] = wr_data;
            end
        end
    end

    // NOTE: the lanes are reset because unwritten lanes of a final word must read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lanes_q <= '0;
        else        lanes_q <= lanes_d;
    end

    assign lanes = lanes_q;

endmodule

// File: rtl/byte_packer.sv
// Packs an 8-bit message stream into 64-bit words for the padder.
// Optional message-length counter: define BYTE_PACKER_LEN_COUNT_EN.
module byte_packer
    import sha3_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic [WORD_W-1:0] out,
    output logic              out_ready,
    output logic              is_last,
    output logic [2:0]        byte_num,
    input  logic              ack
`ifdef BYTE_PACKER_LEN_COUNT_EN
    ,
    output logic [LEN_W-1:0]  msg_len
`endif
);

    pack_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              out_ready_q, out_ready_d;
    logic              is_last_q, is_last_d;
    logic [2:0]        byte_num_q, byte_num_d;
    logic              byte_ready_q, byte_ready_d;

    logic [WORD_W-1:0]     lanes;
    logic [WORD_W-1:0]     merged;
    logic [WORD_BYTES-1:0] lane_wr;
    logic                  lane_clr;
    logic                  xfer;

    assign xfer   = byte_ready_q & (byte_valid | byte_last);
    assign merged = byte_valid ? (lanes | place_byte(byte_in, cnt_q)) : lanes;

    byte_lane_reg u_lanes (
        .clk     (clk),
        .reset   (reset),
        .clr     (lane_clr),
        .wr_en   (lane_wr),
        .wr_data (byte_in),
        .lanes   (lanes)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        out_ready_d  = out_ready_q;
        is_last_d    = is_last_q;
        byte_num_d   = byte_num_q;
        byte_ready_d = byte_ready_q;
        lane_wr      = '0;
        lane_clr     = 1'b0;

        case (state_q)
            FILL: begin
                // byte_ready is registered, so it rises one edge after reset release.
                byte_ready_d = 1'b1;
                if (xfer) begin
                    if (byte_valid && !byte_last && cnt_q != CNT_W'(WORD_BYTES-1)) begin
                        lane_wr[cnt_q] = 1'b1;
                        cnt_d          = cnt_q + 1'b1;
                    end else begin
                        // Word complete: either 8 bytes gathered or the message ended.
                        out_d        = merged;
                        out_ready_d  = 1'b1;
                        byte_ready_d = 1'b0;
                        lane_clr     = 1'b1;
                        cnt_d        = '0;
                        state_d      = SEND;
                        is_last_d    = 1'b0;
                        byte_num_d   = '0;
                        if (byte_last) begin
                            if (byte_valid && cnt_q == CNT_W'(WORD_BYTES-1)) begin
                                state_d = SEND_EMPTY;
                            end else begin
                                is_last_d  = 1'b1;
                                byte_num_d = byte_valid ? cnt_q + 1'b1 : cnt_q;
                            end
                        end
                    end
                end
            end
            SEND: begin
                byte_ready_d = 1'b0;
                if (ack) begin
                    out_d        = '0;
                    out_ready_d  = 1'b0;
                    is_last_d    = 1'b0;
                    byte_num_d   = '0;
                    cnt_d        = '0;
                    byte_ready_d = 1'b1;
                    state_d      = FILL;
                end
            end
            SEND_EMPTY: begin
                byte_ready_d = 1'b0;
                if (ack) begin
                    out_d      = '0;
                    is_last_d  = 1'b1;
                    byte_num_d = '0;
                    state_d    = SEND;
                end
            end
            default: begin
                out_ready_d  = 1'b0;
                byte_ready_d = 1'b0;
                state_d      = FILL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            out_q        <= '0;
            out_ready_q  <= 1'b0;
            is_last_q    <= 1'b0;
            byte_num_q   <= '0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_ready_q  <= out_ready_d;
            is_last_q    <= is_last_d;
            byte_num_q   <= byte_num_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign out        = out_q;
    assign out_ready  = out_ready_q;
    assign is_last    = is_last_q;
    assign byte_num   = byte_num_q;

`ifdef BYTE_PACKER_LEN_COUNT_EN
    logic [LEN_W-1:0] msg_len_q, msg_len_d;
    logic             new_msg_q, new_msg_d;

    // The count freezes after byte_last and reloads on the next message's first transfer.
    always_comb begin
        msg_len_d = msg_len_q;
        new_msg_d = new_msg_q;
        if (xfer) begin
            new_msg_d = byte_last;
            if (new_msg_q) begin
                msg_len_d = byte_valid ? LEN_W'(1) : '0;
            end else if (byte_valid && msg_len_q != '1) begin
                msg_len_d = msg_len_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_len_q <= '0;
            new_msg_q <= 1'b1;
        end else begin
            msg_len_q <= msg_len_d;
            new_msg_q <= new_msg_d;
        end
    end

    assign msg_len = msg_len_q;
`endif

endmodule
